// File: rtl/ex_ic_queue.sv
// ex_ic_queue: completion buffer between the execute and complete stages.
// It takes up to two results per cycle (ALU on port 0, multiplier on port 1) and
// hands one per cycle to the complete stage. Optional macro: EX_IC_QUEUE_BYPASS_EN.

package ex_ic_queue_pkg;
    typedef struct packed {
        logic [31:0] result;
        logic [5:0]  dest_tag;
        logic [4:0]  rob_idx;
        logic        exception;
    } EX_IC_PACKET;

    localparam int unsigned EX_IC_PACKET_W = $bits(EX_IC_PACKET);
endpackage

module ex_ic_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      flush,
    input  logic                                      in0_valid,
    input  logic [ex_ic_queue_pkg::EX_IC_PACKET_W-1:0] in0_packet,
    output logic                                      in0_ready,
    input  logic                                      in1_valid,
    input  logic [ex_ic_queue_pkg::EX_IC_PACKET_W-1:0] in1_packet,
    output logic                                      in1_ready,
    output logic                                      out_valid,
    output logic [ex_ic_queue_pkg::EX_IC_PACKET_W-1:0] out_packet,
    input  logic                                      out_ready,
    output logic [$clog2(DEPTH+1)-1:0]                count
);

    localparam int unsigned PKT_W = ex_ic_queue_pkg::EX_IC_PACKET_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [PKT_W-1:0] entry [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] nxt_occ;
    logic             rdy0_q;
    logic             rdy1_q;
    logic             enq0;
    logic             enq1;
    logic             wr0;
    logic             deq;
    logic             stored;

    // Ready flags are registered copies of the next occupancy, so they are 0
    // throughout reset and never see a same-cycle dequeue.
    assign in0_ready = rdy0_q;
    assign in1_ready = rdy1_q;
    assign count     = occ;
    assign stored    = (occ != '0);
    assign tail_p1   = tail + PTR_W'(1);
    assign enq0      = in0_valid & rdy0_q;
    assign enq1      = in1_valid & rdy1_q;
    assign deq       = stored & out_ready;

`ifdef EX_IC_QUEUE_BYPASS_EN
    logic bypass;

    // rdy0_q gates the bypass so the outputs stay at reset values while in reset.
    assign bypass     = ~stored & ~flush & in0_valid & rdy0_q;
    assign wr0        = enq0 & ~(bypass & out_ready);
    assign out_valid  = stored | bypass;
    assign out_packet = (~stored & bypass) ? in0_packet : entry[head];
`else
    assign wr0        = enq0;
    assign out_valid  = stored;
    assign out_packet = entry[head];
`endif

    always_comb begin
        nxt_occ = occ;
        if (flush) begin
            nxt_occ = '0;
        end else begin
            nxt_occ = occ + CNT_W'(wr0) + CNT_W'(enq1) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            occ    <= nxt_occ;
            rdy0_q <= (nxt_occ < CNT_W'(DEPTH));
            rdy1_q <= (nxt_occ < CNT_W'(DEPTH-1));
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (deq) begin
                    head <= head + PTR_W'(1);
                end
                tail <= tail + PTR_W'(wr0) + PTR_W'(enq1);
                if (wr0) begin
                    entry[tail] <= in0_packet;
                end
                // in1 lands behind in0 when both write, otherwise at tail.
                if (enq1) begin
                    entry[wr0 ? tail_p1 : tail] <= in1_packet;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_ic_queue.sv
// Self-checking bench for ex_ic_queue: queue-based reference model plus directed vectors.
module tb_ex_ic_queue;
    import ex_ic_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in0_valid = 1'b0;
    logic        in1_valid = 1'b0;
    logic        out_ready = 1'b0;
    EX_IC_PACKET in0_pkt = '0;
    EX_IC_PACKET in1_pkt = '0;
    logic        in0_ready;
    logic        in1_ready;
    logic        out_valid;
    logic [EX_IC_PACKET_W-1:0] out_packet;
    logic [2:0]  count;
    EX_IC_PACKET op;

    int checks = 0;
    int errors = 0;

    EX_IC_PACKET m_q[$];
    bit          m_live = 1'b0;
    int          obs[$];
    bit          collect = 1'b0;

    assign op = EX_IC_PACKET'(out_packet);

    ex_ic_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in0_valid  (in0_valid),
        .in0_packet (in0_pkt),
        .in0_ready  (in0_ready),
        .in1_valid  (in1_valid),
        .in1_packet (in1_pkt),
        .in1_ready  (in1_ready),
        .out_valid  (out_valid),
        .out_packet (out_packet),
        .out_ready  (out_ready),
        .count      (count)
    );

    always #5 clock = ~clock;

    function automatic EX_IC_PACKET mk(input int tag);
        EX_IC_PACKET p;
        p.result    = 32'(tag) * 32'h0101_0101;
        p.dest_tag  = 6'(tag);
        p.rob_idx   = 5'(tag);
        p.exception = 1'(tag);
        return p;
    endfunction

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: an ordered list of stored packets.
    always @(negedge reset) begin
        m_q.delete();
        m_live = 1'b0;
    end

    always @(posedge clock) begin
        if (reset) begin
            int  sz;
            bit  r0, r1, byp_take;
            sz = m_q.size();
            r0 = m_live && (sz < DEPTH);
            r1 = m_live && (sz < DEPTH - 1);
`ifdef EX_IC_QUEUE_BYPASS_EN
            byp_take = r0 && (sz == 0) && !flush && in0_valid && out_ready;
`else
            byp_take = 1'b0;
`endif
            if (flush) begin
                m_q.delete();
            end else begin
                if (sz != 0 && out_ready) void'(m_q.pop_front());
                if (in0_valid && r0 && !byp_take) m_q.push_back(in0_pkt);
                if (in1_valid && r1) m_q.push_back(in1_pkt);
            end
            m_live = 1'b1;
        end
    end

    // Single compare process against the model, every cycle.
    always @(negedge clock) begin
        int          sz;
        bit          e_r0, e_r1, e_valid;
        EX_IC_PACKET e_pkt;
        sz    = m_q.size();
        e_r0  = m_live && (sz < DEPTH);
        e_r1  = m_live && (sz < DEPTH - 1);
        e_valid = (sz != 0);
        e_pkt = (sz != 0) ? m_q[0] : '0;
`ifdef EX_IC_QUEUE_BYPASS_EN
        if (sz == 0 && e_r0 && !flush && in0_valid) begin
            e_valid = 1'b1;
            e_pkt   = in0_pkt;
        end
`endif
        lit("model_count", 64'(count), 64'(sz));
        lit("model_in0_ready", 64'(in0_ready), 64'(e_r0));
        lit("model_in1_ready", 64'(in1_ready), 64'(e_r1));
        lit("model_out_valid", 64'(out_valid), 64'(e_valid));
        if (e_valid || !reset) lit("model_out_packet", 64'(out_packet), 64'(e_pkt));
        if (collect && out_valid && out_ready) obs.push_back(int'(op.dest_tag));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        #2;
        lit("rst_count", 64'(count), 64'd0);
        lit("rst_in0_ready", 64'(in0_ready), 64'd0);
        lit("rst_in1_ready", 64'(in1_ready), 64'd0);
        lit("rst_out_valid", 64'(out_valid), 64'd0);
        lit("rst_out_packet", 64'(out_packet), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        lit("rel_in0_ready_pre", 64'(in0_ready), 64'd0);
        step();
        lit("rel_in0_ready", 64'(in0_ready), 64'd1);
        lit("rel_in1_ready", 64'(in1_ready), 64'd1);

`ifdef EX_IC_QUEUE_BYPASS_EN
        // Bypass on an empty queue
        in0_pkt = mk(9); in0_valid = 1'b1; out_ready = 1'b1;
        #1;
        lit("byp_valid", 64'(out_valid), 64'd1);
        lit("byp_tag", 64'(op.dest_tag), 64'd9);
        step();
        in0_valid = 1'b0; out_ready = 1'b0;
        lit("byp_count", 64'(count), 64'd0);
`else
        // Single packet, one-cycle latency
        in0_pkt = mk(5); in0_valid = 1'b1; out_ready = 1'b1;
        step();
        in0_valid = 1'b0;
        lit("t1_valid", 64'(out_valid), 64'd1);
        lit("t1_tag", 64'(op.dest_tag), 64'd5);
        lit("t1_count", 64'(count), 64'd1);
        step();
        lit("t1_count_after", 64'(count), 64'd0);
        lit("t1_valid_after", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
`endif

        // Dual enqueue ordering
        in0_pkt = mk(3); in1_pkt = mk(7); in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
        step();
        in0_valid = 1'b0; in1_valid = 1'b0;
        lit("t2_count", 64'(count), 64'd2);
        lit("t2_head_tag", 64'(op.dest_tag), 64'd3);
        out_ready = 1'b1;
        step();
        lit("t2_second_tag", 64'(op.dest_tag), 64'd7);
        lit("t2_count1", 64'(count), 64'd1);
        step();
        lit("t2_count0", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Near-full readiness
        in0_pkt = mk(20); in1_pkt = mk(21); in0_valid = 1'b1; in1_valid = 1'b1;
        step();
        in0_pkt = mk(22); in1_valid = 1'b0;
        step();
        lit("t3_count3", 64'(count), 64'd3);
        in0_pkt = mk(23); in1_pkt = mk(24); in1_valid = 1'b1;
        lit("t3_in0_ready", 64'(in0_ready), 64'd1);
        lit("t3_in1_ready", 64'(in1_ready), 64'd0);
        step();
        lit("t3_full_count", 64'(count), 64'd4);
        lit("t3_full_r0", 64'(in0_ready), 64'd0);
        lit("t3_full_r1", 64'(in1_ready), 64'd0);
        in0_valid = 1'b0; out_ready = 1'b1;
        step();
        lit("t3_deq_count", 64'(count), 64'd3);
        lit("t3_deq_r0", 64'(in0_ready), 64'd1);
        lit("t3_deq_r1", 64'(in1_ready), 64'd0);
        in1_valid = 1'b0;
        repeat (3) step();
        lit("t3_drained", 64'(count), 64'd0);

        // Ten packets across pointer wrap, ports alternating
        obs.delete();
        collect = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            out_ready = (i % 3 != 0);
            if (i % 2 == 1) begin
                in0_pkt = mk(i); in0_valid = 1'b1;
                n = 0;
                while (!in0_ready && n < 20) begin out_ready = 1'b1; step(); n++; end
            end else begin
                in1_pkt = mk(i); in1_valid = 1'b1;
                n = 0;
                while (!in1_ready && n < 20) begin out_ready = 1'b1; step(); n++; end
            end
            if (n >= 20) lit("t4_ready_timeout", 64'(n), 64'd0);
            step();
            in0_valid = 1'b0; in1_valid = 1'b0;
        end
        out_ready = 1'b1;
        n = 0;
        while (count != 0 && n < 20) begin step(); n++; end
        lit("t4_drain_count", 64'(count), 64'd0);
        step();
        collect = 1'b0;
        lit("t4_obs_size", 64'(obs.size()), 64'd10);
        for (int k = 0; k < obs.size() && k < 10; k++) lit("t4_order", 64'(obs[k]), 64'(k + 1));
        out_ready = 1'b0;

        // Flush beats enqueue and dequeue
        in0_pkt = mk(30); in1_pkt = mk(31); in0_valid = 1'b1; in1_valid = 1'b1;
        step();
        in0_pkt = mk(32); in1_valid = 1'b0;
        step();
        lit("t5_count3", 64'(count), 64'd3);
        flush = 1'b1; in0_pkt = mk(12); out_ready = 1'b1;
        step();
        flush = 1'b0; in0_valid = 1'b0; out_ready = 1'b0;
        lit("t5_count", 64'(count), 64'd0);
        lit("t5_valid", 64'(out_valid), 64'd0);
        step();
        lit("t5_count_still", 64'(count), 64'd0);

        // Asynchronous reset mid-cycle
        in0_pkt = mk(40); in1_pkt = mk(41); in0_valid = 1'b1; in1_valid = 1'b1;
        step();
        in0_valid = 1'b0; in1_valid = 1'b0;
        lit("t6_count2", 64'(count), 64'd2);
        #2 reset = 1'b0;
        #1;
        lit("t6_valid", 64'(out_valid), 64'd0);
        lit("t6_count", 64'(count), 64'd0);
        lit("t6_r0", 64'(in0_ready), 64'd0);
        lit("t6_r1", 64'(in1_ready), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        step();
        lit("t6_rel_r0", 64'(in0_ready), 64'd1);
        lit("t6_rel_r1", 64'(in1_ready), 64'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_ic_queue.md
# ex_ic_queue

Completion buffer between the execute stage and the complete stage. It accepts up to two finished-instruction packets per cycle, one from the ALU and one from the multiplier. It stores them in arrival order and presents one packet per cycle to the complete stage, which owns the single CDB. It absorbs same-cycle FU collisions so that no result is lost before it reaches the ROB and, from there, retirement.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- flush  input  1  synchronous squash; empties the queue on the next edge.
- in0_valid  input  1  ALU result valid.
- in0_packet  input  $bits(EX_IC_PACKET)  ALU result.
- in0_ready  output  1  queue accepts in0 this cycle.
- in1_valid  input  1  multiplier result valid.
- in1_packet  input  $bits(EX_IC_PACKET)  multiplier result.
- in1_ready  output  1  queue accepts in1 this cycle.
- out_valid  output  1  head entry is presented.
- out_packet  output  $bits(EX_IC_PACKET)  head entry.
- out_ready  input  1  complete stage takes the head this cycle (CDB granted).
- count  output  $clog2(DEPTH+1)  occupied entries.

## Operation
- Circular buffer: storage array, head pointer, tail pointer ($clog2(DEPTH) bits each, wrapping modulo DEPTH), occupancy counter.
- Readiness is computed from registered occupancy only; a same-cycle dequeue is not credited.
  - in0_ready = (DEPTH - count >= 1).
  - in1_ready = (DEPTH - count >= 2).
  - The ALU has priority; the multiplier holds its result while in1_ready is 0.
- Enqueue:
  - A port enqueues when valid and ready are both 1.
  - If both ports enqueue in the same cycle, in0 is written at tail and in1 at tail+1. Tail then advances by 2.
  - If only one port enqueues, it is written at tail and tail advances by 1.
- Dequeue: out_valid = (count != 0) and out_packet = entry[head]. When out_valid and out_ready are both 1, head advances by 1.
- Counter: next count = count + enq0 + enq1 - deq. It never exceeds DEPTH and never underflows.
- Boundaries:
  - Full: both ready outputs are 0. out_ready=1 still dequeues, and the inputs see freed space next cycle.
  - Empty: out_valid=0, and out_ready is ignored.
  - Simultaneous enqueue and dequeue on the last free slot is legal and leaves count unchanged.
  - Pointer wrap is silent; tail+1 wraps independently of tail.
  - Flush has priority over every enqueue and dequeue in that cycle. Head, tail and count go to 0 and inputs presented that cycle are dropped.
  - Reset asserted mid-operation clears state asynchronously. While reset=0 all outputs are held at their reset values.
- Reset values:
  - out_valid=0, out_packet=0, count=0, in0_ready=0, in1_ready=0.
  - After release, both ready outputs rise to 1 in the same cycle, because they are derived from count=0.

## Timing
- Latency from enqueue edge to out_valid is 1 cycle; out_packet comes from registered storage.
- Throughput is 1 dequeue per cycle and up to 2 enqueues per cycle.
- in*_ready depends only on registered state, so there is no combinational path from in*_valid or out_ready to any ready output.
- out_valid and out_packet depend only on registered state, except when EX_IC_QUEUE_BYPASS_EN is defined.

## Configuration
- EX_IC_QUEUE_BYPASS_EN defined:
  - When count==0, flush==0 and in0_valid==1, out_valid=1 and out_packet=in0_packet in the same cycle.
  - If out_ready=1 that cycle, in0 is consumed without being written. If in1 also enqueues, it is written at tail.
  - If out_ready=0, in0 is enqueued normally.
  - Bypass creates a combinational path from in0 to out.
- Macro undefined: there is no bypass, and the minimum latency is 1 cycle.

## Test plan
- Reset, then release; in0_valid=1 with dest tag 5 at cycle 1 and out_ready=1 -> cycle 2: out_valid=1 with tag 5, count=1; cycle 3: count=0, out_valid=0.
- Same-cycle in0 tag 3 and in1 tag 7, out_ready=0 -> next cycle count=2 and out_packet tag 3; raise out_ready -> tags leave in order 3 then 7 on consecutive cycles.
- DEPTH=4 with count=3, both inputs valid and out_ready=0 -> in0_ready=1, in1_ready=0. Only in0 enqueues, count=4 and both ready outputs go to 0. One dequeue -> count=3 and in0_ready=1.
- Fill and drain 10 packets with tags 1..10, both ports alternating -> output order matches enqueue order across pointer wrap, and count returns to 0.
- count=3, flush=1 with in0_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0; the in0 packet is never seen.
- Assert reset=0 asynchronously mid-cycle with count=2 -> out_valid=0, count=0 and ready outputs 0 immediately, without waiting for a clock edge. With EX_IC_QUEUE_BYPASS_EN defined, an empty queue with in0 tag 9 and out_ready=1 -> out_packet tag 9 in the same cycle and count stays 0.
